// File: rtl/spc_cfg_loader.sv
// Loads the vin_spc configuration chain serially from a parallel word.
// Define CFG_READBACK_EN to add a second verifying pass that sets err.
module spc_cfg_loader #(
    parameter int NBITS      = 33,
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 8
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             start,
    input  logic [NBITS-1:0] word,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             Cfg_in,
    output logic             SClk,
    output logic             ChainResetn,
    input  logic             Cfg_out
);

    localparam int MX = (DIV > RST_CYCLES) ? DIV : RST_CYCLES;
    localparam int CW = $clog2(MX + 1);
    localparam int BW = $clog2(NBITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t           state;
    logic [NBITS-1:0] sreg;
    logic [NBITS-1:0] rot;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic             last_pass;
    logic             half_end;
    logic             bit_end;

    // Shift/or form stays legal when NBITS is 1.
    assign rot      = (sreg << 1) | (sreg >> (NBITS - 1));
    assign half_end = (cnt == CW'(DIV - 1));
    assign bit_end  = (bit_cnt == BW'(NBITS - 1));

`ifdef CFG_READBACK_EN
    assign last_pass = (state == S_VERIFY);
`else
    assign last_pass = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state       <= S_IDLE;
            sreg        <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Cfg_in      <= 1'b0;
            SClk        <= 1'b0;
            ChainResetn <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sreg        <= word;
                        busy        <= 1'b1;
                        ChainResetn <= 1'b0;
                        cnt         <= '0;
                        state       <= S_CRST;
                    end
                end
                S_CRST: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        cnt         <= '0;
                        bit_cnt     <= '0;
                        ChainResetn <= 1'b1;
                        SClk        <= 1'b0;
                        Cfg_in      <= sreg[NBITS-1];
                        state       <= S_SHIFT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_SHIFT, S_VERIFY: begin
                    if (!half_end) begin
                        cnt <= cnt + CW'(1);
                    end else if (!SClk) begin
                        cnt  <= '0;
                        SClk <= 1'b1;
                    end else begin
                        // Falling edge: rotate so the image is intact after a pass.
                        cnt  <= '0;
                        SClk <= 1'b0;
                        sreg <= rot;
                        if (bit_end && last_pass) begin
                            bit_cnt <= '0;
                            Cfg_in  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else if (bit_end) begin
                            bit_cnt <= '0;
                            Cfg_in  <= rot[NBITS-1];
                            state   <= S_VERIFY;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            Cfg_in  <= rot[NBITS-1];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CFG_READBACK_EN
    // One Clk after a rise the tail already shows the next image bit,
    // which is the MSB of the rotated register.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            err <= 1'b0;
        end else if (state == S_VERIFY && SClk && cnt == '0
                     && Cfg_out != rot[NBITS-1]) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_cfg_out;
    assign unused_cfg_out = Cfg_out;
    assign err            = 1'b0;
`endif

endmodule
